// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// FSM state encoding and the default operand width.
package shift_add_mult_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_add_n.sv
// WIDTH-bit ripple-carry adder built from half/full adder cells.
// Bit 0 has no carry-in, so it is a half adder.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module add_n
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);
    // carry[i] is the carry out of bit i
    logic [WIDTH-1:0] carry;

    ha u_ha0 (
        .a (a_i[0]),
        .b (b_i[0]),
        .s (s_o[0]),
        .c (carry[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        fa u_fa (
            .a  (a_i[i]),
            .b  (b_i[i]),
            .ci (carry[i-1]),
            .s  (s_o[i]),
            .co (carry[i])
        );
    end

    assign c_o = carry[WIDTH-1];
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one shared WIDTH-bit adder
// reused over WIDTH iterations, product held on p_o until the next result.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] p_o
);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH:0]   shifted;

    assign addend = mplier[0] ? mcand : '0;

    add_n #(.WIDTH(WIDTH)) u_add (
        .a_i (acc[WIDTH-1:0]),
        .b_i (addend),
        .s_o (sum),
        .c_o (carry)
    );

    // {acc, mplier} next value: the add result joins the retiring multiplier
    // bits and the whole thing moves one place right.
    assign shifted = {carry, sum, mplier} >> 1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            p_o    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mcand  <= a_i;
                        mplier <= b_i;
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        busy_o <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc    <= shifted[2*WIDTH:WIDTH];
                    mplier <= shifted[WIDTH-1:0];
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        p_o   <= shifted[2*WIDTH-1:0];
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // The product fits in 2*WIDTH bits, so the spare accumulator bit is
    // always clear once the last shift has happened.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == ST_DONE)
            assert (acc[WIDTH] == 1'b0);
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: vector table, hand sequences for held start
// and mid-operation reset, and random operands at WIDTH=8 and WIDTH=16.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;
    logic [63:0] prev8 = '0, prev16 = '0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .p_o(p8)
    );

    shift_add_mult_ctrl #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .a_i(a16), .b_i(b16),
        .busy_o(busy16), .done_o(done16), .p_o(p16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start16 = s; a16 = a[15:0]; b16 = b[15:0];
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [63:0] get_p(input int w);
        return (w == 8) ? {48'd0, p8} : {32'd0, p16};
    endfunction

    // One multiply; called #1 after a rising edge.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp);
        logic [63:0] prev;
        int lat, nbusy;
        bit stable;
        prev = (w == 8) ? prev8 : prev16;
        drive(w, 1'b1, a, b);
        @(posedge clk); #1;
        // operands may change freely once accepted
        drive(w, 1'b0, $urandom, $urandom);
        nbusy  = int'(get_busy(w));
        lat    = 0;
        stable = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k < w && get_p(w) != prev) stable = 1'b0;
            if (get_done(w)) begin
                lat = k;
                break;
            end
            nbusy += int'(get_busy(w));
        end
        chk($sformatf("latency_w%0d", w), 64'(lat), 64'(w + 1));
        chk($sformatf("product_w%0d_%0dx%0d", w, a, b), get_p(w), exp);
        chk($sformatf("p_hold_w%0d", w), 64'(stable), 64'd1);
        chk($sformatf("busy_cycles_w%0d", w), 64'(nbusy), 64'(w + 1));
        @(posedge clk); #1;
        chk($sformatf("done_single_w%0d", w), 64'(get_done(w)), 64'd0);
        if (w == 8) prev8 = exp; else prev16 = exp;
    endtask

    initial begin
        vec_t vecs[7];
        int acc_cyc[$];
        logic [63:0] dones[$];
        bit busy_prev, saw_done;
        logic [31:0] ra, rb;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[5] = '{a: 8'd255, b: 8'd1,   p: 16'd255};
        vecs[6] = '{a: 8'd128, b: 8'd2,   p: 16'd256};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_p", 64'(p8), 64'd0);
        chk("reset_p16", 64'(p16), 64'd0);

        foreach (vecs[i])
            op(8, 32'(vecs[i].a), 32'(vecs[i].b), 64'(vecs[i].p));

        // start held high; operands change mid-CALC and must be ignored
        drive(8, 1'b1, 32'd3, 32'd5);
        busy_prev = 1'b0;
        for (int cyc = 1; cyc <= 60 && dones.size() < 2; cyc++) begin
            @(posedge clk); #1;
            if (busy8 && !busy_prev) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 2) start8 = 1'b0;
            end
            if (acc_cyc.size() == 1 && cyc == acc_cyc[0] + 3) begin
                a8 = 8'd7; b8 = 8'd9;
            end
            if (done8) dones.push_back(64'(p8));
            busy_prev = busy8;
        end
        chk("held_accepts", 64'(acc_cyc.size()), 64'd2);
        chk("held_dones", 64'(dones.size()), 64'd2);
        if (acc_cyc.size() == 2)
            chk("held_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd10);
        if (dones.size() == 2) begin
            chk("held_first", dones[0], 64'd15);
            chk("held_second", dones[1], 64'd63);
        end
        prev8 = 64'd63;
        repeat (3) @(posedge clk);
        #1;

        // reset during the 4th CALC cycle of 100*100
        drive(8, 1'b1, 32'd100, 32'd100);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy8), 64'd0);
        chk("rst_mid_p", 64'(p8), 64'd0);
        chk("rst_mid_done", 64'(done8), 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", 64'(saw_done), 64'd0);
        prev8 = '0;
        prev16 = '0;
        op(8, 32'd6, 32'd7, 64'd42);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & 32'hFF;
            rb = $urandom & 32'hFF;
            op(8, ra, rb, 64'(ra) * 64'(rb));
            ra = $urandom & 32'hFFFF;
            rb = $urandom & 32'hFFFF;
            op(16, ra, rb, 64'(ra) * 64'(rb));
        end
        op(16, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
